// File: rtl/sram_responder_if.sv
// Control and address side of the asynchronous 16-bit SRAM conduit.
// The data bus stays a plain inout port on the responder.
interface sram_responder_if #(
    parameter int ADDR_W = 19
);
    logic              OE_N;
    logic              CE_N;
    logic              WE_N;
    logic [1:0]        BE_N;
    logic [ADDR_W-1:0] A;

    modport master (output OE_N, CE_N, WE_N, BE_N, A);
    modport slave  (input  OE_N, CE_N, WE_N, BE_N, A);
endinterface

// File: rtl/sram_responder.sv
// Device-side model of an async 16-bit SRAM: registered inputs, per-byte writes,
// configurable read latency, write and contention debug counters.
//
// state      | meaning
// IDLE       | bus not selected, D released
// READ_WAIT  | read condition held, counting towards READ_LAT
// READ_DRIVE | driving latched read data on enabled bytes
// WRITE      | holding a pending word, commits when write condition ends
module sram_responder #(
    parameter int ADDR_W   = 19,
    parameter int DATA_W   = 16,
    parameter int DEPTH_W  = 10,
    parameter int READ_LAT = 2
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    sram_responder_if.slave   sram,
    inout  wire  [DATA_W-1:0] sram_D,
    output logic [15:0]       wr_count,
    output logic [7:0]        contention_cnt,
    output logic              rd_active
);

    typedef enum logic [1:0] {IDLE, READ_WAIT, READ_DRIVE, WRITE} state_t;

    localparam logic [2:0] LAT = 3'(READ_LAT);

    state_t            state_q, state_d;
    logic              s_oe_n_q, s_ce_n_q, s_we_n_q;
    logic [1:0]        s_be_n_q;
    logic [ADDR_W-1:0] s_a_q;
    logic [DATA_W-1:0] s_d_q;

    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [1:0]        drv_en_q, drv_en_d;

    logic [ADDR_W-1:0] pend_a_q, pend_a_d;
    logic [DATA_W-1:0] pend_d_q, pend_d_d;
    logic [1:0]        pend_be_n_q, pend_be_n_d;

    logic [15:0]       wr_count_q;
    logic [7:0]        cont_q;

    logic              read_cond, write_cond;
    logic              commit, capture, start_rd, load_rd;

    logic [DATA_W-1:0] mem [2**DEPTH_W];

    assign write_cond = !s_ce_n_q && !s_we_n_q;
    assign read_cond  = !s_ce_n_q && !s_oe_n_q && s_we_n_q;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            s_oe_n_q <= 1'b1;
            s_ce_n_q <= 1'b1;
            s_we_n_q <= 1'b1;
            s_be_n_q <= 2'b11;
            s_a_q    <= '0;
            s_d_q    <= '0;
        end else begin
            s_oe_n_q <= sram.OE_N;
            s_ce_n_q <= sram.CE_N;
            s_we_n_q <= sram.WE_N;
            s_be_n_q <= sram.BE_N;
            s_a_q    <= sram.A;
            s_d_q    <= sram_D;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rd_addr_d   = rd_addr_q;
        dout_d      = dout_q;
        drv_en_d    = '0;
        pend_a_d    = pend_a_q;
        pend_d_d    = pend_d_q;
        pend_be_n_d = pend_be_n_q;
        commit      = 1'b0;
        capture     = 1'b0;
        start_rd    = 1'b0;
        load_rd     = 1'b0;

        case (state_q)
            IDLE: begin
                if (write_cond) begin
                    state_d = WRITE;
                    capture = 1'b1;
                end else if (read_cond) begin
                    start_rd = 1'b1;
                end
            end
            READ_WAIT: begin
                if (write_cond) begin
                    state_d = WRITE;
                    capture = 1'b1;
                end else if (read_cond) begin
                    if (s_a_q != rd_addr_q) begin
                        start_rd = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q + 3'd1 == LAT) begin
                            state_d = READ_DRIVE;
                            load_rd = 1'b1;
                        end
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            READ_DRIVE: begin
                if (write_cond) begin
                    state_d = WRITE;
                    capture = 1'b1;
                end else if (read_cond) begin
                    if (s_a_q != rd_addr_q) begin
                        start_rd = 1'b1;
                    end else begin
                        drv_en_d = ~s_be_n_q;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                if (write_cond) begin
                    // a new address while held closes out the previous word
                    commit  = (s_a_q != pend_a_q);
                    capture = 1'b1;
                end else begin
                    commit = 1'b1;
                    if (read_cond) begin
                        start_rd = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (capture) begin
            pend_a_d    = s_a_q;
            pend_d_d    = s_d_q;
            pend_be_n_d = s_be_n_q;
        end

        if (start_rd) begin
            rd_addr_d = s_a_q;
            cnt_d     = 3'd1;
            if (LAT == 3'd1) begin
                state_d = READ_DRIVE;
                load_rd = 1'b1;
            end else begin
                state_d = READ_WAIT;
            end
        end

        if (load_rd) begin
            dout_d   = mem[rd_addr_d[DEPTH_W-1:0]];
            drv_en_d = ~s_be_n_q;
        end

        if (state_d != READ_WAIT && state_d != READ_DRIVE) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rd_addr_q   <= '0;
            dout_q      <= '0;
            drv_en_q    <= '0;
            pend_a_q    <= '0;
            pend_d_q    <= '0;
            pend_be_n_q <= 2'b11;
            wr_count_q  <= '0;
            cont_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd_addr_q   <= rd_addr_d;
            dout_q      <= dout_d;
            drv_en_q    <= drv_en_d;
            pend_a_q    <= pend_a_d;
            pend_d_q    <= pend_d_d;
            pend_be_n_q <= pend_be_n_d;
            if (commit) begin
                wr_count_q <= wr_count_q + 16'd1;
            end
            if (write_cond && (|drv_en_q) && (cont_q != 8'hFF)) begin
                cont_q <= cont_q + 8'd1;
            end
        end
    end

    // storage is deliberately left out of reset
    always_ff @(posedge clk_clk) begin
        if (commit) begin
            if (!pend_be_n_q[0]) mem[pend_a_q[DEPTH_W-1:0]][7:0]  <= pend_d_q[7:0];
            if (!pend_be_n_q[1]) mem[pend_a_q[DEPTH_W-1:0]][15:8] <= pend_d_q[15:8];
        end
    end

    assign sram_D[7:0]  = drv_en_q[0] ? dout_q[7:0]  : 8'bz;
    assign sram_D[15:8] = drv_en_q[1] ? dout_q[15:8] : 8'bz;

    assign wr_count       = wr_count_q;
    assign contention_cnt = cont_q;
    assign rd_active      = |drv_en_q;

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: vector table for write/readback plus
// hand sequences for mid-read address change, contention and reset.
module tb_sram_responder;

    localparam int LAT = 2;
    localparam int NV  = 10;

    logic        clk;
    logic        rst_n;
    logic [15:0] tb_d;
    logic        tb_d_en;
    wire  [15:0] sram_d;
    logic [15:0] wr_count;
    logic [7:0]  contention_cnt;
    logic        rd_active;

    int          n_checks;
    int          n_err;
    logic [15:0] exp_wr;
    logic [7:0]  exp_cont;

    typedef struct {
        logic        do_wr;
        logic [18:0] wa;
        logic [15:0] wd;
        logic [1:0]  wbe;
        logic [18:0] ra;
        logic [1:0]  rbe;
        logic [15:0] exp_d;
        logic        exp_act;
    } vec_t;

    vec_t vecs [NV];

    sram_responder_if #(.ADDR_W(19)) sram ();

    assign sram_d = tb_d_en ? tb_d : 16'hzzzz;
    pullup pu_d (sram_d);

    sram_responder #(
        .ADDR_W  (19),
        .DATA_W  (16),
        .DEPTH_W (10),
        .READ_LAT(LAT)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .sram          (sram),
        .sram_D        (sram_d),
        .wr_count      (wr_count),
        .contention_cnt(contention_cnt),
        .rd_active     (rd_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_idle();
        sram.CE_N = 1'b1;
        sram.OE_N = 1'b1;
        sram.WE_N = 1'b1;
        sram.BE_N = 2'b11;
        tb_d_en   = 1'b0;
    endtask

    task automatic read_begin(input logic [18:0] a, input logic [1:0] be);
        sram.CE_N = 1'b0;
        sram.OE_N = 1'b0;
        sram.WE_N = 1'b1;
        sram.A    = a;
        sram.BE_N = be;
        tb_d_en   = 1'b0;
    endtask

    task automatic write_pins(input logic [18:0] a, input logic [15:0] d, input logic [1:0] be, input logic drive);
        sram.CE_N = 1'b0;
        sram.WE_N = 1'b0;
        sram.A    = a;
        sram.BE_N = be;
        tb_d      = d;
        tb_d_en   = drive;
    endtask

    task automatic write_op(input logic [18:0] a, input logic [15:0] d, input logic [1:0] be);
        sram.OE_N = 1'b1;
        write_pins(a, d, be, 1'b1);
        cyc(2);
        bus_idle();
        cyc(2);
        exp_wr = exp_wr + 16'd1;
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        exp_wr   = '0;
        exp_cont = '0;
        tb_d     = '0;
        sram.A   = '0;
        bus_idle();

        vecs[0] = '{1'b1, 19'h00005, 16'hBEEF, 2'b00, 19'h00005, 2'b00, 16'hBEEF, 1'b1};
        vecs[1] = '{1'b1, 19'h00007, 16'h1234, 2'b00, 19'h00007, 2'b00, 16'h1234, 1'b1};
        vecs[2] = '{1'b1, 19'h00007, 16'hAB00, 2'b01, 19'h00007, 2'b00, 16'hAB34, 1'b1};
        vecs[3] = '{1'b0, 19'h00000, 16'h0000, 2'b11, 19'h00007, 2'b10, 16'hFF34, 1'b1};
        vecs[4] = '{1'b1, 19'h40003, 16'h5A5A, 2'b00, 19'h00003, 2'b00, 16'h5A5A, 1'b1};
        vecs[5] = '{1'b1, 19'h00009, 16'hC3C3, 2'b00, 19'h00009, 2'b00, 16'hC3C3, 1'b1};
        vecs[6] = '{1'b0, 19'h00000, 16'h0000, 2'b11, 19'h00003, 2'b01, 16'h5AFF, 1'b1};
        vecs[7] = '{1'b1, 19'h00005, 16'h0000, 2'b11, 19'h00005, 2'b00, 16'hBEEF, 1'b1};
        vecs[8] = '{1'b1, 19'h003FF, 16'h8001, 2'b00, 19'h007FF, 2'b00, 16'h8001, 1'b1};
        vecs[9] = '{1'b0, 19'h00000, 16'h0000, 2'b11, 19'h00009, 2'b11, 16'hFFFF, 1'b0};

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        cyc(2);
        check("reset_wr_count", wr_count, 16'h0);
        check("reset_contention", contention_cnt, 8'h0);
        check("reset_rd_active", rd_active, 1'b0);
        check("reset_d_released", sram_d, 16'hFFFF);
        rst_n = 1'b1;
        cyc(2);

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].do_wr) begin
                write_op(vecs[i].wa, vecs[i].wd, vecs[i].wbe);
                check($sformatf("vec%0d_wr_count", i), wr_count, exp_wr);
            end
            read_begin(vecs[i].ra, vecs[i].rbe);
            cyc(LAT);
            check($sformatf("vec%0d_not_yet_driven", i), rd_active, 1'b0);
            cyc(1);
            check($sformatf("vec%0d_read_data", i), sram_d, vecs[i].exp_d);
            check($sformatf("vec%0d_rd_active", i), rd_active, vecs[i].exp_act);
            bus_idle();
            cyc(2);
            check($sformatf("vec%0d_released", i), sram_d, 16'hFFFF);
        end

        // address change while the read is held
        read_begin(19'h00003, 2'b00);
        cyc(LAT + 1);
        check("addr_chg_first_data", sram_d, 16'h5A5A);
        sram.A = 19'h00009;
        cyc(1);
        check("addr_chg_still_old", sram_d, 16'h5A5A);
        cyc(1);
        check("addr_chg_released", rd_active, 1'b0);
        check("addr_chg_released_d", sram_d, 16'hFFFF);
        cyc(LAT - 1);
        check("addr_chg_new_data", sram_d, 16'hC3C3);
        bus_idle();
        cyc(2);

        // write asserted while the responder drives
        read_begin(19'h00005, 2'b00);
        cyc(LAT + 1);
        check("cont_pre_driving", rd_active, 1'b1);
        write_pins(19'h0000A, 16'h1357, 2'b00, 1'b1);
        cyc(1);
        check("cont_pre_count", contention_cnt, 8'h0);
        cyc(1);
        exp_cont = 8'd1;
        check("cont_count_one", contention_cnt, exp_cont);
        check("cont_released", rd_active, 1'b0);
        check("cont_bus_is_tb", sram_d, 16'h1357);
        cyc(1);
        bus_idle();
        cyc(2);
        exp_wr = exp_wr + 16'd1;
        check("cont_wr_count", wr_count, exp_wr);
        read_begin(19'h0000A, 2'b00);
        cyc(LAT + 1);
        check("cont_write_committed", sram_d, 16'h1357);
        bus_idle();
        cyc(2);

        for (int i = 0; i < 299; i++) begin
            read_begin(19'h00005, 2'b00);
            cyc(LAT + 1);
            sram.OE_N = 1'b1;
            write_pins(19'h00020, 16'h0000, 2'b11, 1'b0);
            cyc(1);
            bus_idle();
            cyc(2);
            exp_wr = exp_wr + 16'd1;
            if (exp_cont != 8'hFF) exp_cont = exp_cont + 8'd1;
            if (i == 100 || i == 253 || i == 298) begin
                check($sformatf("cont_loop%0d_count", i), contention_cnt, exp_cont);
            end
        end
        check("cont_saturated", contention_cnt, 8'hFF);
        check("cont_loop_wr_count", wr_count, exp_wr);

        // reset while driving releases D without waiting for a clock
        read_begin(19'h00009, 2'b00);
        cyc(LAT + 1);
        check("rst_pre_driving", sram_d, 16'hC3C3);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_rd_active", rd_active, 1'b0);
        check("rst_async_d", sram_d, 16'hFFFF);
        check("rst_wr_count", wr_count, 16'h0);
        check("rst_contention", contention_cnt, 8'h0);
        bus_idle();
        cyc(1);
        rst_n = 1'b1;
        exp_wr = '0;
        cyc(1);

        // reset during a held write discards it
        sram.OE_N = 1'b1;
        write_pins(19'h00005, 16'h7777, 2'b00, 1'b1);
        cyc(3);
        #2 rst_n = 1'b0;
        #1;
        check("rst_wr_discard_count", wr_count, 16'h0);
        bus_idle();
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
        read_begin(19'h00005, 2'b00);
        cyc(LAT + 1);
        check("rst_wr_mem_unchanged", sram_d, 16'hBEEF);
        check("rst_wr_count_after", wr_count, 16'h0);
        bus_idle();
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
